// File: rtl/stopwatch_ctrl.sv
// Front-panel control for the stopwatch: synchronizes and debounces the two
// active-low keys, then runs the IDLE/RUN/LAP/STOP machine that drives run/hold/clr.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    output logic       run,
    output logic       hold,
    output logic       clr,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_LAP  = 2'b10,
        S_STOP = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] w_key_raw;
    logic [1:0] w_press;
    logic       w_ps;
    logic       w_pl;

    assign w_key_raw = {key_lap_n, key_start_n};

    // Bit 0 is START/STOP, bit 1 is LAP/RESET; each key gets an identical chain.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic             r_sync1;
            logic             r_sync2;
            logic             r_stable;
            logic             r_stable_d;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1    <= 1'b1;
                    r_sync2    <= 1'b1;
                    r_stable   <= 1'b1;
                    r_stable_d <= 1'b1;
                    r_cnt      <= '0;
                end else begin
                    r_sync1    <= w_key_raw[gi];
                    r_sync2    <= r_sync1;
                    r_stable_d <= r_stable;
                    if (r_sync2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_stable <= r_sync2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            // Falling edge of the debounced level only: releases are silent.
            assign w_press[gi] = r_stable_d & ~r_stable;
        end
    endgenerate

    assign w_ps = w_press[0];
    assign w_pl = w_press[1];

    state_t r_state;
    state_t w_state_next;
    logic   r_clr;
    logic   w_clr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_clr   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_clr   <= w_clr_next;
        end
    end

    // A start press always takes priority over a simultaneous lap press.
    always_comb begin
        w_state_next = r_state;
        w_clr_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ps) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_ps)      w_state_next = S_STOP;
                else if (w_pl) w_state_next = S_LAP;
            end
            S_LAP: begin
                if (w_ps)      w_state_next = S_STOP;
                else if (w_pl) w_state_next = S_RUN;
            end
            S_STOP: begin
                if (w_ps) begin
                    w_state_next = S_RUN;
                end else if (w_pl) begin
                    w_state_next = S_IDLE;
                    w_clr_next   = 1'b1;
                end
            end
        endcase
    end

    assign run   = (r_state == S_RUN) || (r_state == S_LAP);
    assign hold  = (r_state == S_LAP);
    assign clr   = r_clr;
    assign state = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4: key presses push expected
// state/clr per cycle into a scoreboard that a negedge monitor drains.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_start_n = 1'b0;
    logic       key_lap_n = 1'b0;
    logic       run;
    logic       hold;
    logic       clr;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_start_n(key_start_n),
        .key_lap_n(key_lap_n),
        .run(run),
        .hold(hold),
        .clr(clr),
        .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       clr;
        string      nm;
    } exp_t;

    typedef struct {
        bit         s;
        bit         l;
        logic [1:0] prev;
        logic [1:0] nxt;
        logic       clr;
        string      nm;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_outputs(input string nm, input logic [1:0] st, input logic c);
        check({nm, "_state"}, {30'd0, state}, {30'd0, st});
        check({nm, "_run"},   {31'd0, run},   {31'd0, (st == 2'b01) || (st == 2'b10)});
        check({nm, "_hold"},  {31'd0, hold},  {31'd0, (st == 2'b10)});
        check({nm, "_clr"},   {31'd0, clr},   {31'd0, c});
    endtask

    task automatic push(input int c, input logic [1:0] st, input logic cl, input string nm);
        exp_t e;
        e.cyc = c;
        e.st  = st;
        e.clr = cl;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) check({e.nm, "_missed"}, cyc, e.cyc);
            else check_outputs(e.nm, e.st, e.clr);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the next rising edge is the first to sample the key.
    task automatic press(input bit s, input bit l, input logic [1:0] prev,
                         input logic [1:0] nxt, input logic cl, input string nm);
        int k;
        if (s) key_start_n = 1'b0;
        if (l) key_lap_n = 1'b0;
        k = cyc + 1;
        push(k + 5, prev, 1'b0, {nm, "_early"});
        push(k + 6, nxt, cl, nm);
        push(k + 7, nxt, 1'b0, {nm, "_after"});
        tick(8);
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        tick(14);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_outputs("reset_async", 2'b00, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        int k;
        int c2;
        vecs[0] = '{1'b1, 1'b0, 2'b00, 2'b01, 1'b0, "seq_start"};
        vecs[1] = '{1'b0, 1'b1, 2'b01, 2'b10, 1'b0, "seq_lap1"};
        vecs[2] = '{1'b0, 1'b1, 2'b10, 2'b01, 1'b0, "seq_lap2"};
        vecs[3] = '{1'b1, 1'b0, 2'b01, 2'b11, 1'b0, "seq_stop"};
        vecs[4] = '{1'b0, 1'b1, 2'b11, 2'b00, 1'b1, "seq_clr"};
        vecs[5] = '{1'b1, 1'b0, 2'b00, 2'b01, 1'b0, "sim_start"};
        vecs[6] = '{1'b1, 1'b1, 2'b01, 2'b11, 1'b0, "sim_both"};
        vecs[7] = '{1'b0, 1'b1, 2'b11, 2'b00, 1'b1, "sim_clr"};

        // Reset with both keys held low; start stays low across release.
        tick(3);
        check_outputs("in_reset", 2'b00, 1'b0);
        rst = 1'b0;
        k = cyc + 1;
        push(k + 5, 2'b00, 1'b0, "rst_rel_early");
        push(k + 6, 2'b01, 1'b0, "rst_rel_run");
        key_lap_n = 1'b1;
        tick(8);
        push(cyc + 50, 2'b01, 1'b0, "held_50");
        push(cyc + 100, 2'b01, 1'b0, "held_100");
        tick(101);
        key_start_n = 1'b1;
        tick(14);

        do_reset();

        // Two 3-cycle lows split by a 1-cycle high never complete a debounce.
        key_start_n = 1'b0;
        push(cyc + 5, 2'b00, 1'b0, "bounce_5");
        push(cyc + 10, 2'b00, 1'b0, "bounce_10");
        push(cyc + 20, 2'b00, 1'b0, "bounce_20");
        tick(3);
        key_start_n = 1'b1;
        tick(1);
        key_start_n = 1'b0;
        tick(3);
        key_start_n = 1'b1;
        tick(20);

        press(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, "lap_idle");

        for (int i = 0; i < 8; i++) begin
            press(vecs[i].s, vecs[i].l, vecs[i].prev, vecs[i].nxt, vecs[i].clr, vecs[i].nm);
        end

        // Reset while in LAP with the start debounce counter at 2.
        press(1'b1, 1'b0, 2'b00, 2'b01, 1'b0, "mid_start");
        press(1'b0, 1'b1, 2'b01, 2'b10, 1'b0, "mid_lap");
        check_outputs("mid_in_lap", 2'b10, 1'b0);
        key_start_n = 1'b0;
        tick(4);
        rst = 1'b1;
        #1;
        check_outputs("mid_rst_async", 2'b00, 1'b0);
        key_start_n = 1'b1;
        tick(2);
        rst = 1'b0;
        c2 = cyc;
        push(c2 + 1, 2'b00, 1'b0, "mid_no_clr1");
        push(c2 + 2, 2'b00, 1'b0, "mid_no_clr2");
        tick(3);
        press(1'b1, 1'b0, 2'b00, 2'b01, 1'b0, "post_rst");

        tick(5);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.nm, "_unchecked"}, cyc, e.cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-panel control stage for the stopwatch. It takes the two raw, active-low, bouncing push-buttons (START/STOP and LAP/RESET) and synchronizes and debounces them. A run/lap/stop state machine then drives the BCD counter chain and display path. The block sits directly upstream of the 1 Hz divider and the cascaded BCD counters: `run` gates counting, `clr` zeroes the counters, and `hold` freezes the seven-segment display for lap readout.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive `clk` cycles a synchronized key must differ from its stable level before the new level is accepted; legal range ≥ 2.
- `CNT_W`, default 18: width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_start_n`  in  1  raw START/STOP button, low = pressed, asynchronous to `clk`.
- `key_lap_n`  in  1  raw LAP/RESET button, low = pressed, asynchronous to `clk`.
- `run`  out  1  count enable to divider/counters; 1 = counting.
- `hold`  out  1  display freeze; 1 = display shows latched lap value.
- `clr`  out  1  one-cycle synchronous clear pulse to the counter chain.
- `state`  out  2  current FSM state, for debug/LEDs.

## Operation
- **Synchronizer:** each key passes through a 2-flop synchronizer; both flops reset to 1.
- **Debounce, per key:**
  - `stable` resets to 1 and `cnt` resets to 0.
  - At each edge where the synchronized value equals `stable`, `cnt` <= 0.
  - On a mismatch with `cnt == DEBOUNCE_CYCLES-1`, `stable` <= synchronized value and `cnt` <= 0.
  - On any other mismatch, `cnt` <= `cnt`+1.
- **Press detect:** `stable_d` is a 1-cycle delayed copy of `stable`, resetting to 1. `press = stable_d & ~stable`, a single pulse per accepted press. Releases generate nothing, and holding a key gives exactly one pulse.
- **FSM states** (encoding shown on `state`); `ps` = start press, `pl` = lap press:
  - IDLE (2'b00): `ps` -> RUN. `pl` is ignored.
  - RUN (2'b01): `ps` -> STOP; `pl` -> LAP.
  - LAP (2'b10): `ps` -> STOP; `pl` -> RUN.
  - STOP (2'b11): `ps` -> RUN; `pl` -> IDLE and `clr` is asserted.
- **Simultaneous `ps` and `pl`** in the same cycle: `ps` wins and `pl` is discarded.
- **Outputs, decoded from registered state (Moore):**
  - `run` = 1 in RUN and LAP.
  - `hold` = 1 in LAP only.
  - `clr` is a registered flag, set only at the STOP->IDLE edge and cleared at the next edge (exactly 1 cycle wide).
- **Reset values:** `run`=0, `hold`=0, `clr`=0, `state`=2'b00, all synchronizer/stable/stable_d flops = 1, counters = 0.
- **Reset mid-operation** (any state, any debounce count): the block returns to IDLE immediately with no `clr` pulse, since the counters have their own reset. A key held low through reset release is accepted as a press after the normal debounce delay.

## Timing
- Raw key falls and is first sampled at edge k:
  - The synchronizer output goes low after edge k+1.
  - `stable` falls at edge k+1+DEBOUNCE_CYCLES, provided there is no bounce.
  - `press` is high during the following cycle.
  - The state (and therefore `run`, `hold`, `clr`) updates at edge k+2+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no press and resets `cnt`.
- Release debounce is symmetric, but no pulse is produced on release.
- A new press is only detectable after a debounced release: minimum of DEBOUNCE_CYCLES low cycles, then DEBOUNCE_CYCLES high cycles, then DEBOUNCE_CYCLES low cycles.
- `rst` takes effect asynchronously. Release is assumed synchronized externally.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset:** `rst`=1 with both keys low -> `run`=0, `hold`=0, `clr`=0, `state`=00 during reset. After release, with `key_start_n` held low, RUN is entered exactly 6 edges later.
- **Clean start:** `key_start_n` low at edge k -> `state`=01 and `run`=1 after edge k+6, not earlier. Holding the key for 100 cycles gives no further transition.
- **Bounce:** `key_start_n` low for 3 cycles, high for 1, low for 3, then high -> no press, state stays IDLE.
- **Full sequence:** start, lap, lap, start, lap presses (each clean, separated by 20 cycles) -> states 01, 10, 01, 11, 00. `hold`=1 only in the LAP interval. `clr` is high for exactly 1 cycle coincident with entry to IDLE.
- **Simultaneous presses in RUN:** both keys fall at the same edge -> STOP (11), no LAP entry. Lap in IDLE -> no state change and `clr`=0.
- **Mid-operation reset:** `rst` pulsed in LAP with a debounce count at 2 -> outputs go to 0 immediately, no `clr` pulse, and the next clean start press requires the full 6 edges.
